// File: rtl/grouping_sweep_checker.sv
// grouping_sweep_checker
// Drives every input combination of an N_IN-input combinational function in
// ascending order, one per clock, and compares the function's output against
// a golden truth table. Reports pass/fail, the mismatch count and the lowest
// failing index.
//
// Build option: define SWEEP_CHECKER_CAPTURE_EN to record the observed truth
// table in observed_tt. When it is undefined, observed_tt is tied to zero.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | after reset; waiting for start
// S_SWEEP | presenting vec, comparing dut_out against GOLDEN[vec]
// S_DONE  | results final and held; start launches a new sweep at once

module grouping_sweep_checker #(
   parameter int                      N_IN   = 5,
   parameter logic [(1<<N_IN)-1:0]    GOLDEN = 32'hCFC89F7F
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       start,
   input  logic                       dut_out,
   output logic [N_IN-1:0]            vec,
   output logic                       busy,
   output logic                       done,
   output logic                       pass,
   output logic [N_IN:0]              mismatch_count,
   output logic [N_IN-1:0]            first_fail_idx,
   output logic                       first_fail_valid,
   output logic [(1<<N_IN)-1:0]       observed_tt
);

   localparam logic [N_IN-1:0] VEC_ONE  = 1;
   localparam logic [N_IN-1:0] VEC_LAST = '1;
   localparam logic [N_IN:0]   CNT_ONE  = 1;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SWEEP = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   state_t            state_q;
   logic [N_IN-1:0]   vec_q;
   logic [N_IN-1:0]   vec_d;
   logic              busy_q;
   logic              done_q;
   logic              pass_q;
   logic [N_IN:0]     count_q;
   logic [N_IN:0]     count_d;
   logic [N_IN-1:0]   ffi_q;
   logic              ffv_q;
   logic              mismatch;
   logic              accept_start;

   assign mismatch     = (dut_out != GOLDEN[vec_q]);
   assign vec_d        = vec_q + VEC_ONE;
   assign count_d      = mismatch ? (count_q + CNT_ONE) : count_q;
   assign accept_start = start && ((state_q == S_IDLE) || (state_q == S_DONE));

   // Sweep sequencer: state, stimulus vector and result registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         vec_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         pass_q  <= 1'b0;
         count_q <= '0;
         ffi_q   <= '0;
         ffv_q   <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE, S_DONE: begin
               if (start) begin
                  state_q <= S_SWEEP;
                  vec_q   <= '0;
                  busy_q  <= 1'b1;
                  done_q  <= 1'b0;
                  pass_q  <= 1'b0;
                  count_q <= '0;
                  ffi_q   <= '0;
                  ffv_q   <= 1'b0;
               end
            end
            S_SWEEP: begin
               count_q <= count_d;
               if (mismatch && !ffv_q) begin
                  ffi_q <= vec_q;
                  ffv_q <= 1'b1;
               end
               if (vec_q == VEC_LAST) begin
                  // last compare is folded into pass via count_d
                  state_q <= S_DONE;
                  vec_q   <= '0;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  pass_q  <= (count_d == '0);
               end else begin
                  vec_q <= vec_d;
               end
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

`ifdef SWEEP_CHECKER_CAPTURE_EN
   logic [(1<<N_IN)-1:0] tt_q;

   // Record each observed output bit at the index being presented
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tt_q <= '0;
      end else if (accept_start) begin
         tt_q <= '0;
      end else if (state_q == S_SWEEP) begin
         tt_q[vec_q] <= dut_out;
      end
   end

   assign observed_tt = tt_q;
`else
   assign observed_tt = '0;
`endif

   assign vec              = vec_q;
   assign busy             = busy_q;
   assign done             = done_q;
   assign pass             = pass_q;
   assign mismatch_count   = count_q;
   assign first_fail_idx   = ffi_q;
   assign first_fail_valid = ffv_q;

endmodule

// File: tb/tb_grouping_sweep_checker.sv
// Self-checking bench for grouping_sweep_checker: table of DUT behaviours with
// hand-computed results, plus sequences for restart, ignored start and reset.

module tb_grouping_sweep_checker;

   localparam logic [31:0] GOLD = 32'hCFC89F7F;

   logic        clk;
   logic        reset;
   logic        start;
   logic        dut_out;
   logic [4:0]  vec;
   logic        busy;
   logic        done;
   logic        pass;
   logic [5:0]  mismatch_count;
   logic [4:0]  first_fail_idx;
   logic        first_fail_valid;
   logic [31:0] observed_tt;

   int checks;
   int failures;
   int mode;

   grouping_sweep_checker dut (
      .clk              (clk),
      .reset            (reset),
      .start            (start),
      .dut_out          (dut_out),
      .vec              (vec),
      .busy             (busy),
      .done             (done),
      .pass             (pass),
      .mismatch_count   (mismatch_count),
      .first_fail_idx   (first_fail_idx),
      .first_fail_valid (first_fail_valid),
      .observed_tt      (observed_tt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // function-under-test models
   // 0 correct, 1 stuck-at-0, 2 stuck-at-1, 3 inverted, 4 wrong at 2,5,9
   always_comb begin
      dut_out = 1'b0;
      case (mode)
         0: dut_out = GOLD[vec];
         1: dut_out = 1'b0;
         2: dut_out = 1'b1;
         3: dut_out = ~GOLD[vec];
         4: dut_out = GOLD[vec] ^ ((vec == 5'd2) || (vec == 5'd5) || (vec == 5'd9));
         default: dut_out = GOLD[vec];
      endcase
   end

   typedef struct {
      int          mode;
      int          cnt;
      int          ffi;
      int          ffv;
      int          pass;
      logic [31:0] tt;
   } vec_t;

   vec_t tbl[4];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] exp_tt(input logic [31:0] full);
`ifdef SWEEP_CHECKER_CAPTURE_EN
      return full;
`else
      return 32'h0;
`endif
   endfunction

   // start is applied for one edge; poke>0 re-pulses start when vec==poke
   task automatic run_sweep(input int poke);
      start = 1'b1;
      tick();
      start = 1'b0;
      check("start_busy", {31'b0, busy}, 32'd1);
      check("start_vec", {27'b0, vec}, 32'd0);
      check("start_done", {31'b0, done}, 32'd0);
      if (poke == 0) start = 1'b0;
      for (int i = 1; i <= 32; i++) begin
         tick();
         start = 1'b0;
         if (i < 32) begin
            check("walk_vec", {27'b0, vec}, i);
            check("walk_done", {31'b0, done}, 32'd0);
            if (poke > 0 && i == poke) start = 1'b1;
         end else begin
            check("end_done", {31'b0, done}, 32'd1);
            check("end_busy", {31'b0, busy}, 32'd0);
            check("end_vec", {27'b0, vec}, 32'd0);
         end
      end
   endtask

   task automatic check_results(input vec_t r);
      check("count", {26'b0, mismatch_count}, r.cnt);
      check("first_idx", {27'b0, first_fail_idx}, r.ffi);
      check("first_valid", {31'b0, first_fail_valid}, r.ffv);
      check("pass", {31'b0, pass}, r.pass);
      check("observed_tt", observed_tt, exp_tt(r.tt));
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_vec"}, {27'b0, vec}, 32'd0);
      check({tag, "_busy"}, {31'b0, busy}, 32'd0);
      check({tag, "_done"}, {31'b0, done}, 32'd0);
      check({tag, "_pass"}, {31'b0, pass}, 32'd0);
      check({tag, "_count"}, {26'b0, mismatch_count}, 32'd0);
      check({tag, "_ffi"}, {27'b0, first_fail_idx}, 32'd0);
      check({tag, "_ffv"}, {31'b0, first_fail_valid}, 32'd0);
      check({tag, "_tt"}, observed_tt, 32'd0);
   endtask

   initial begin
      vec_t clean;
      checks   = 0;
      failures = 0;
      mode     = 0;
      start    = 1'b0;
      reset    = 1'b1;

      tbl[0] = '{mode: 0, cnt: 0,  ffi: 0, ffv: 0, pass: 1, tt: 32'hCFC89F7F};
      tbl[1] = '{mode: 1, cnt: 22, ffi: 0, ffv: 1, pass: 0, tt: 32'h00000000};
      tbl[2] = '{mode: 2, cnt: 10, ffi: 7, ffv: 1, pass: 0, tt: 32'hFFFFFFFF};
      tbl[3] = '{mode: 3, cnt: 32, ffi: 0, ffv: 1, pass: 0, tt: 32'h30376080};
      clean  = tbl[0];

      tick();
      tick();
      check_all_zero("reset");
      reset = 1'b0;
      tick();
      check_all_zero("idle");

      // table-driven sweeps, each restarting straight from DONE
      for (int t = 0; t < 4; t++) begin
         mode = tbl[t].mode;
         run_sweep(0);
         check_results(tbl[t]);
      end

      // start re-pulsed at vec==10 is ignored; done still lands at edge k+32
      mode = 2;
      run_sweep(10);
      check_results(tbl[2]);

      // start held high through DONE: exactly one DONE cycle, then restart
      mode  = 1;
      start = 1'b1;
      tick();
      check("hold_busy", {31'b0, busy}, 32'd1);
      for (int i = 1; i < 32; i++) begin
         tick();
         check("hold_done_low", {31'b0, done}, 32'd0);
      end
      tick();
      check("hold_done_high", {31'b0, done}, 32'd1);
      check_results(tbl[1]);
      tick();
      start = 1'b0;
      check("hold_restart_busy", {31'b0, busy}, 32'd1);
      check("hold_restart_done", {31'b0, done}, 32'd0);
      check("hold_restart_vec", {27'b0, vec}, 32'd0);
      for (int i = 1; i <= 32; i++) tick();
      check("hold_second_done", {31'b0, done}, 32'd1);
      check_results(tbl[1]);

      // reset mid-sweep at vec==17 after three mismatches (indices 2,5,9)
      mode  = 4;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 1; i <= 17; i++) tick();
      check("mid_vec", {27'b0, vec}, 32'd17);
      check("mid_count", {26'b0, mismatch_count}, 32'd3);
      check("mid_ffi", {27'b0, first_fail_idx}, 32'd2);
      #2;
      reset = 1'b1;
      #1;
      check_all_zero("async_reset");
      @(negedge clk);
      reset = 1'b0;
      tick();
      check_all_zero("post_reset");

      mode = 0;
      run_sweep(0);
      check_results(clean);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // absolute time bound so the run always terminates
   initial begin
      #200000;
      $display("FAIL timeout actual=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
